// File: rtl/cu_pkg.sv
// Shared opcodes, ALU functions and FSM states for the multi-cycle control unit.
package cu_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_LDI  = 5'b01110;
    localparam logic [4:0] OP_ADDI = 5'b01111;
    localparam logic [4:0] OP_LD   = 5'b10000;
    localparam logic [4:0] OP_ST   = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: maps an opcode onto ALU function and datapath class flags.
module cu_decode
    import cu_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] op,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            is_mem,
    output logic            is_st,
    output logic            has_wb,
    output logic            legal
);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        is_mem      = 1'b0;
        is_st       = 1'b0;
        has_wb      = 1'b0;
        legal       = 1'b1;
        unique case (op)
            OP_W'(OP_NOP), OP_W'(OP_HALT): ;
            OP_W'(OP_ADD): has_wb = 1'b1;
            OP_W'(OP_SUB): begin
                alu_op = ALU_SUB;
                has_wb = 1'b1;
            end
            OP_W'(OP_AND): begin
                alu_op = ALU_AND;
                has_wb = 1'b1;
            end
            OP_W'(OP_OR): begin
                alu_op = ALU_OR;
                has_wb = 1'b1;
            end
            OP_W'(OP_XOR): begin
                alu_op = ALU_XOR;
                has_wb = 1'b1;
            end
            OP_W'(OP_LDI): begin
                alu_op      = ALU_PASSB;
                alu_src_imm = 1'b1;
                has_wb      = 1'b1;
            end
            OP_W'(OP_ADDI): begin
                alu_src_imm = 1'b1;
                has_wb      = 1'b1;
            end
            // address = rs + imm for both memory ops
            OP_W'(OP_LD): begin
                alu_src_imm = 1'b1;
                is_mem      = 1'b1;
                has_wb      = 1'b1;
            end
            OP_W'(OP_ST): begin
                alu_src_imm = 1'b1;
                is_mem      = 1'b1;
                is_st       = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: instruction register, DECODE/EXEC/MEM/WB sequencer
// and retired-instruction counter.
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int INSTR_W = 17,
    parameter int OP_W    = 5,
    parameter int RA_W    = 4,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [RA_W-1:0]    rd_addr,
    output logic [RA_W-1:0]    rs_addr,
    output logic [RA_W-1:0]    rt_addr,
    output logic [DATA_W-1:0]  imm,
    output logic [3:0]         alu_op,
    output logic               alu_src_imm,
    output logic               reg_we,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    localparam int IMM_W = INSTR_W - OP_W - RA_W;

    state_t             state;
    state_t             state_nx;
    logic [INSTR_W-1:0] ir;
    logic [OP_W-1:0]    op;
    logic [3:0]         d_alu;
    logic               d_src;
    logic               d_mem;
    logic               d_st;
    logic               d_wb;
    logic               d_legal;
    logic               is_halt;
    logic               is_nop;
    logic               retire;

    assign op      = ir[INSTR_W-1 -: OP_W];
    assign is_halt = (op == OP_W'(OP_HALT));
    assign is_nop  = (op == OP_W'(OP_NOP));

    cu_decode #(.OP_W(OP_W)) u_decode (
        .op          (op),
        .alu_op      (d_alu),
        .alu_src_imm (d_src),
        .is_mem      (d_mem),
        .is_st       (d_st),
        .has_wb      (d_wb),
        .legal       (d_legal)
    );

    assign rd_addr     = ir[INSTR_W-OP_W-1 -: RA_W];
    assign rs_addr     = ir[INSTR_W-OP_W-RA_W-1 -: RA_W];
    assign rt_addr     = ir[INSTR_W-OP_W-2*RA_W-1 -: RA_W];
    assign imm         = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign alu_op      = d_alu;
    assign alu_src_imm = d_src;

    // Decoded fields stay stable because ir only reloads on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (instr_valid && instr_ready) begin
            ir <= instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (instr_valid) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (is_halt)                  state_nx = S_HALTED;
                else if (!d_legal || is_nop)  state_nx = S_IDLE;
                else                          state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (d_mem)      state_nx = S_MEM;
                else if (d_wb)  state_nx = S_WB;
                else            state_nx = S_IDLE;
            end
            S_MEM: begin
                if (mem_ack) state_nx = d_wb ? S_WB : S_IDLE;
            end
            S_WB:     state_nx = S_IDLE;
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;
        unique case (state)
            S_IDLE: instr_ready = !rst;
            S_DECODE: begin
                busy    = 1'b1;
                illegal = !d_legal;
                retire  = d_legal && is_nop;
            end
            S_EXEC: busy = 1'b1;
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = d_st;
                retire  = mem_ack && !d_wb;
            end
            S_WB: begin
                busy   = 1'b1;
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboarded directed bench for cu_multicycle; the counter is narrowed so
// that wrap-around is reachable in a short run.
module tb_cu_multicycle;

    localparam int CNT_W  = 4;
    localparam int EV_WB  = 0;
    localparam int EV_ILL = 1;
    localparam int EV_MEM = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             instr_valid = 1'b0;
    logic             mem_ack = 1'b0;
    logic [16:0]      instr = '0;
    logic             instr_ready;
    logic             alu_src_imm;
    logic             reg_we;
    logic             mem_req;
    logic             mem_we;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [3:0]       rd_addr;
    logic [3:0]       rs_addr;
    logic [3:0]       rt_addr;
    logic [3:0]       alu_op;
    logic [15:0]      imm;
    logic [CNT_W-1:0] retired;

    typedef struct {
        int kind;
        int cyc;
        int rd;
        int rs;
        int rt;
        int imm;
        int alu;
        int src;
        int we;
        int req;
    } exp_t;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   cyc       = 0;
    int   ack_delay = 1;
    int   wcnt      = 0;
    int   reqcnt    = 0;

    cu_multicycle #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rd_addr     (rd_addr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL stray event: got kind %0d at cycle %0d want none",
                     kind, cyc);
        end else begin
            e = sb.pop_front();
            chk("event kind", kind, e.kind);
            chk("event cycle", cyc, e.cyc);
            if (kind == EV_WB) begin
                chk("wb rd", rd_addr, e.rd);
                chk("wb rs", rs_addr, e.rs);
                chk("wb rt", rt_addr, e.rt);
                chk("wb imm", imm, e.imm);
                chk("wb alu_op", alu_op, e.alu);
                chk("wb alu_src_imm", alu_src_imm, e.src);
            end else if (kind == EV_MEM) begin
                chk("mem we", mem_we, e.we);
                chk("mem imm", imm, e.imm);
                chk("mem req cycles", reqcnt, e.req);
            end
        end
    endtask

    // Monitor: every reg_we / illegal / memory completion pops one entry.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mem_req) reqcnt++;
            else         reqcnt = 0;
            if (reg_we)                  check_event(EV_WB);
            else if (illegal)            check_event(EV_ILL);
            else if (mem_req && mem_ack) check_event(EV_MEM);
        end
    end

    // Memory model: acknowledges on the ack_delay-th cycle of a request.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_req) begin
            wcnt++;
            mem_ack = (wcnt == ack_delay);
        end else begin
            wcnt    = 0;
            mem_ack = 1'b0;
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, instr_ready, 1);
    endtask

    task automatic issue(input logic [16:0] w, output int a);
        wait_ready("ready before issue");
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        a           = cyc;
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a;
        repeat (2) @(negedge clk);
        chk("reset instr_ready", instr_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset halted", halted, 0);
        chk("reset retired", retired, 0);
        chk("reset mem_req", mem_req, 0);
        chk("reset reg_we", reg_we, 0);
        chk("reset imm", imm, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", instr_ready, 1);

        // LDI r1,3
        issue(17'b01110_0001_0000_0011, a);
        sb.push_back('{EV_WB, a + 2, 1, 0, 3, 16'h0003, 5, 1, 0, 0});
        wait_ready("drain ldi");
        chk("retired after ldi", retired, 1);

        // ADD r1,r0,r2
        issue(17'b00001_0001_0000_0010, a);
        sb.push_back('{EV_WB, a + 2, 1, 0, 2, 16'h0002, 0, 0, 0, 0});
        repeat (3) begin
            @(negedge clk);
            chk("ready low while busy", instr_ready, 0);
        end
        @(negedge clk);
        chk("ready back-to-back", instr_ready, 1);
        chk("retired after add", retired, 2);

        // LD r3, imm 0xFF, four-cycle memory
        ack_delay = 4;
        issue(17'b10000_0011_1111_1111, a);
        sb.push_back('{EV_MEM, a + 5, 0, 0, 0, 16'hFFFF, 0, 0, 0, 4});
        sb.push_back('{EV_WB, a + 6, 3, 15, 15, 16'hFFFF, 0, 1, 0, 0});
        wait_ready("drain ld");
        chk("retired after ld", retired, 3);

        // ST then illegal opcode 01010
        ack_delay = 2;
        issue(17'b10001_0010_0001_0100, a);
        sb.push_back('{EV_MEM, a + 3, 0, 0, 0, 16'h0014, 0, 0, 1, 2});
        wait_ready("drain st");
        chk("retired after st", retired, 4);
        issue(17'b01010_0000_0000_0000, a);
        sb.push_back('{EV_ILL, a, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        @(negedge clk);
        chk("ready after illegal", instr_ready, 1);
        chk("retired after illegal", retired, 4);

        // HALT holds off further instructions
        issue(17'b11111_0000_0000_0000, a);
        @(negedge clk);
        instr       = 17'b01110_0001_0000_0011;
        instr_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("halted flag", halted, 1);
            chk("ready while halted", instr_ready, 0);
        end
        chk("busy while halted", busy, 0);
        chk("retired after halt", retired, 4);
        rst = 1'b1;
        #1;
        chk("halted cleared by rst", halted, 0);
        chk("retired cleared by rst", retired, 0);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after halt reset", instr_ready, 1);

        // counter wrap (2^CNT_W legal NOPs)
        for (int i = 0; i < 15; i++) issue(17'h0, a);
        wait_ready("drain nops");
        chk("retired at max", retired, 15);
        issue(17'h0, a);
        wait_ready("drain wrap nop");
        chk("retired wrapped", retired, 0);

        // ADDI with negative immediate
        issue(17'b01111_0101_1000_0000, a);
        sb.push_back('{EV_WB, a + 2, 5, 8, 0, 16'hFF80, 0, 1, 0, 0});
        wait_ready("drain addi");
        chk("retired after addi", retired, 1);

        // reset in the middle of a memory wait
        ack_delay = 100;
        issue(17'b10000_0011_0000_0001, a);
        repeat (3) @(negedge clk);
        chk("mem_req before abort", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mem_req async abort", mem_req, 0);
        chk("reg_we after abort", reg_we, 0);
        chk("retired after abort", retired, 0);
        @(negedge clk);
        rst       = 1'b0;
        ack_delay = 1;
        repeat (6) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
